// File: rtl/secded_inv_pkg.sv
// Shared constants and types for the inverted Hsiao SECDED(39,32) integrity codec.
package secded_inv_pkg;

   typedef logic [6:0]  syndrome_t;
   typedef logic [38:0] codeword_t;

   localparam logic [31:0] M0 = 32'h2606BD25;
   localparam logic [31:0] M1 = 32'hDEBA8050;
   localparam logic [31:0] M2 = 32'h413D89AA;
   localparam logic [31:0] M3 = 32'h31234ED1;
   localparam logic [31:0] M4 = 32'hC2C1323B;
   localparam logic [31:0] M5 = 32'h2DCC624C;
   localparam logic [31:0] M6 = 32'h98505586;

   localparam logic [6:0][31:0] MASKS = {M6, M5, M4, M3, M2, M1, M0};

   // Check bits 33, 35 and 37 are inverted so an all-zero bus word is not a valid codeword.
   localparam codeword_t INV_MASK = 39'h2A_0000_0000;

   function automatic syndrome_t column(input logic [4:0] j);
      syndrome_t col;
      col = '0;
      for (int i = 0; i < 7; i++) col[i] = MASKS[i][j];
      return col;
   endfunction

endpackage

// File: rtl/secded_inv_39_32_enc_core.sv
// Combinational generator of the 7 raw (non-inverted) check bits for a 32-bit word.
module secded_inv_39_32_enc_core
   import secded_inv_pkg::*;
(
   input  logic [31:0] data,
   output syndrome_t   raw
);

   always_comb begin
      raw = '0;
      for (int i = 0; i < 7; i++) raw[i] = ^(data & MASKS[i]);
   end

endmodule

// File: rtl/secded_inv_39_32_codec.sv
// Inverted SECDED(39,32) codec: combinational encoder plus a one-stage registered checker
// with single-error correction, sticky uncorrectable-error alert and saturating counters.
module secded_inv_39_32_codec
   import secded_inv_pkg::*;
#(
   parameter codeword_t InvMask  = INV_MASK,
   parameter int        CntWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [31:0]         enc_data_i,
   output logic [38:0]         enc_o,
   input  logic                chk_valid_i,
   input  logic [31:0]         chk_data_i,
   input  logic [6:0]          chk_intg_i,
   output logic                chk_valid_o,
   output logic [31:0]         chk_data_o,
   output logic [6:0]          syndrome_o,
   output logic                err_single_o,
   output logic                err_double_o,
   output logic                alert_o,
   input  logic                clr_alert_i,
   output logic [CntWidth-1:0] single_cnt_o,
   output logic [CntWidth-1:0] double_cnt_o
);

   syndrome_t   raw_enc;
   syndrome_t   raw_chk;
   syndrome_t   syn;
   codeword_t   w;
   logic [31:0] flip;
   logic [31:0] corr;
   logic        single_c;
   logic        double_c;

   logic        valid_q;
   logic [31:0] data_q;
   syndrome_t   syn_q;
   logic        single_q;
   logic        double_q;
   logic        alert_q;
   logic [CntWidth-1:0] single_cnt_q;
   logic [CntWidth-1:0] double_cnt_q;

   secded_inv_39_32_enc_core u_enc (
      .data (enc_data_i),
      .raw  (raw_enc)
   );

   assign enc_o = {raw_enc, enc_data_i} ^ InvMask;

   assign w = {chk_intg_i, chk_data_i} ^ InvMask;

   secded_inv_39_32_enc_core u_chk (
      .data (w[31:0]),
      .raw  (raw_chk)
   );

   assign syn = raw_chk ^ w[38:32];

   // Odd syndromes that match neither a data column nor a single check bit are uncorrectable.
   always_comb begin
      flip = '0;
      for (int j = 0; j < 32; j++) flip[j] = (syn == column(5'(j)));
      corr     = w[31:0] ^ flip;
      single_c = (^syn) && ((|flip) || ((syn & (syn - 7'd1)) == 7'd0));
      double_c = (syn != 7'd0) && !single_c;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         syn_q        <= '0;
         single_q     <= 1'b0;
         double_q     <= 1'b0;
         alert_q      <= 1'b0;
         single_cnt_q <= '0;
         double_cnt_q <= '0;
      end else begin
         valid_q <= chk_valid_i;
         if (chk_valid_i) begin
            data_q   <= corr;
            syn_q    <= syn;
            single_q <= single_c;
            double_q <= double_c;
            if (single_c && (single_cnt_q != '1)) single_cnt_q <= single_cnt_q + CntWidth'(1);
            if (double_c && (double_cnt_q != '1)) double_cnt_q <= double_cnt_q + CntWidth'(1);
         end
         // Setting takes priority over a simultaneous clear.
         if (valid_q && double_q)  alert_q <= 1'b1;
         else if (clr_alert_i)     alert_q <= 1'b0;
      end
   end

   assign chk_valid_o  = valid_q;
   assign chk_data_o   = data_q;
   assign syndrome_o   = syn_q;
   assign err_single_o = valid_q & single_q;
   assign err_double_o = valid_q & double_q;
   assign alert_o      = alert_q;
   assign single_cnt_o = single_cnt_q;
   assign double_cnt_o = double_cnt_q;

endmodule

// File: tb/tb_secded_inv_39_32_codec.sv
// Directed bench for the inverted SECDED(39,32) codec with hand-computed expectations.
module tb_secded_inv_39_32_codec;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] enc_data;
   logic [38:0] enc;
   logic        chk_valid;
   logic [31:0] chk_data;
   logic [6:0]  chk_intg;
   logic        chk_valid_q;
   logic [31:0] chk_data_q;
   logic [6:0]  syndrome;
   logic        err_single;
   logic        err_double;
   logic        alert;
   logic        clr_alert;
   logic [7:0]  single_cnt;
   logic [7:0]  double_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   secded_inv_39_32_codec dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enc_data_i   (enc_data),
      .enc_o        (enc),
      .chk_valid_i  (chk_valid),
      .chk_data_i   (chk_data),
      .chk_intg_i   (chk_intg),
      .chk_valid_o  (chk_valid_q),
      .chk_data_o   (chk_data_q),
      .syndrome_o   (syndrome),
      .err_single_o (err_single),
      .err_double_o (err_double),
      .alert_o      (alert),
      .clr_alert_i  (clr_alert),
      .single_cnt_o (single_cnt),
      .double_cnt_o (double_cnt)
   );

   task automatic check(input string tag, input logic [38:0] got, input logic [38:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [6:0] i);
      chk_valid = v;
      chk_data  = d;
      chk_intg  = i;
   endtask

   task automatic check_result(input string tag, input logic [31:0] d, input logic [6:0] s,
                               input logic sgl, input logic dbl);
      check({tag, ".valid"},  39'(chk_valid_q), 39'(1));
      check({tag, ".data"},   39'(chk_data_q), 39'(d));
      check({tag, ".syn"},    39'(syndrome), 39'(s));
      check({tag, ".single"}, 39'(err_single), 39'(sgl));
      check({tag, ".double"}, 39'(err_double), 39'(dbl));
   endtask

   initial begin
      rst = 1'b1; clr_alert = 1'b0; enc_data = '0;
      drive(1'b0, '0, '0);
      step(); step();
      rst = 1'b0;
      check("rst.valid", 39'(chk_valid_q), 39'(0));
      check("rst.data",  39'(chk_data_q), 39'(0));
      check("rst.syn",   39'(syndrome), 39'(0));
      check("rst.err",   39'({err_single, err_double}), 39'(0));
      check("rst.alert", 39'(alert), 39'(0));
      check("rst.cnt",   39'({single_cnt, double_cnt}), 39'(0));

      enc_data = 32'h0;        #1 check("enc.zero", enc, {7'h2A, 32'h0});
      enc_data = 32'hFFFFFFFF; #1 check("enc.ones", enc, {7'h2A, 32'hFFFFFFFF});
      enc_data = 32'h00000013; #1 check("enc.x13",  enc, {7'h7D, 32'h00000013});

      drive(1'b1, 32'h13, 7'h7D); step();
      check_result("clean", 32'h13, 7'h00, 1'b0, 1'b0);

      drive(1'b0, 32'h0, 7'h0); step();
      check("idle.valid", 39'(chk_valid_q), 39'(0));
      check("idle.hold",  39'(chk_data_q), 39'(32'h13));

      drive(1'b1, 32'h33, 7'h7D); step();
      check_result("d5", 32'h13, 7'h15, 1'b1, 1'b0);
      check("d5.cnt", 39'(single_cnt), 39'(1));

      drive(1'b1, 32'h13, 7'h7C); step();
      check_result("c0", 32'h13, 7'h01, 1'b1, 1'b0);
      check("c0.cnt", 39'(single_cnt), 39'(2));

      drive(1'b1, 32'h80000000, 7'h2A); step();
      check_result("d31", 32'h0, 7'h52, 1'b1, 1'b0);
      check("d31.cnt", 39'(single_cnt), 39'(3));

      drive(1'b1, 32'h10, 7'h7D); step();
      check_result("dbl", 32'h10, 7'h4D, 1'b0, 1'b1);
      check("dbl.cnt",     39'(double_cnt), 39'(1));
      check("dbl.alert0",  39'(alert), 39'(0));
      drive(1'b0, 32'h0, 7'h0); step();
      check("dbl.alert1",  39'(alert), 39'(1));
      check("dbl.errq",    39'(err_double), 39'(0));
      step();
      check("dbl.sticky",  39'(alert), 39'(1));
      clr_alert = 1'b1; step(); clr_alert = 1'b0;
      check("dbl.clr",     39'(alert), 39'(0));

      drive(1'b1, 32'h0, 7'h55); step();
      check_result("odd7", 32'h0, 7'h7F, 1'b0, 1'b1);
      check("odd7.cnt", 39'({single_cnt, double_cnt}), 39'({8'd3, 8'd2}));
      drive(1'b0, 32'h0, 7'h0); clr_alert = 1'b1; step();
      check("setwins", 39'(alert), 39'(1));
      step(); clr_alert = 1'b0;
      check("clr2", 39'(alert), 39'(0));

      drive(1'b1, 32'h33, 7'h7D); rst = 1'b1; enc_data = 32'h13; step(); rst = 1'b0;
      drive(1'b0, 32'h0, 7'h0);
      check("rstv.valid", 39'(chk_valid_q), 39'(0));
      check("rstv.data",  39'({chk_data_q, syndrome}), 39'(0));
      check("rstv.err",   39'({err_single, err_double, alert}), 39'(0));
      check("rstv.cnt",   39'({single_cnt, double_cnt}), 39'(0));
      check("rstv.enc",   enc, {7'h7D, 32'h13});

      drive(1'b1, 32'h33, 7'h7D);
      for (int i = 0; i < 254; i++) step();
      check("sat.fe", 39'(single_cnt), 39'(8'hFE));
      step();
      check("sat.ff", 39'(single_cnt), 39'(8'hFF));
      for (int i = 0; i < 10; i++) step();
      check("sat.hold", 39'(single_cnt), 39'(8'hFF));
      check("sat.dbl",  39'(double_cnt), 39'(0));
      drive(1'b0, 32'h0, 7'h0); step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/secded_inv_39_32_codec.md
Name: secded_inv_39_32_codec

Overview:
- Integrity codec for the core's 32-bit instruction and data bus words, based on an inverted Hsiao SECDED(39,32) code.
- Encode path: combinationally generates the 7 integrity bits for an outgoing or checked word.
- Check path: registers a received 39-bit word, computes its syndrome, corrects single-bit errors, flags double-bit errors and raises a sticky alert.
- Sits between the bus interface (rdata/rdata_intg) and the fetch/LSU logic.

Parameters:
- InvMask, 39'h2A_0000_0000, inversion pattern XORed onto the codeword (check bits 33, 35, 37).
- CntWidth, 8, width of the saturating error counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- enc_data_i  in  32  word to encode
- enc_o  out  39  codeword {intg[6:0], data[31:0]}, combinational
- chk_valid_i  in  1  received word valid
- chk_data_i  in  32  received data
- chk_intg_i  in  7  received integrity bits
- chk_valid_o  out  1  registered result valid
- chk_data_o  out  32  corrected data
- syndrome_o  out  7  syndrome
- err_single_o  out  1  single-bit error (corrected)
- err_double_o  out  1  uncorrectable error
- alert_o  out  1  sticky uncorrectable-error alert
- clr_alert_i  in  1  clears alert_o
- single_cnt_o  out  CntWidth  saturating single-error count
- double_cnt_o  out  CntWidth  saturating double-error count

Behaviour:
- Only one clock; reset is synchronous and active-high.
- Check masks M0..M6 over data bits [31:0]:
  - M0 = 32'h2606BD25
  - M1 = 32'hDEBA8050
  - M2 = 32'h413D89AA
  - M3 = 32'h31234ED1
  - M4 = 32'hC2C1323B
  - M5 = 32'h2DCC624C
  - M6 = 32'h98505586
- Encode:
  - raw[i] = ^(enc_data_i & Mi).
  - enc_o = {raw, enc_data_i} ^ InvMask.
  - Purely combinational, no latency.
- Check stage (one register stage, latency 1 cycle):
  - w = {chk_intg_i, chk_data_i} ^ InvMask.
  - s[i] = ^(w[31:0] & Mi) ^ w[32+i].
  - s == 0: no error.
  - ^s == 1: single error. If s matches data column j (the bits of Mi at position j), flip data bit j. If s is one-hot, the error is in a check bit and data passes unchanged. Any other odd-weight s is treated as a double error.
  - s != 0 and ^s == 0: double error; data passes uncorrected.
- Registered outputs update only when chk_valid_i=1. chk_valid_o follows chk_valid_i by one cycle. err_* outputs are qualified by valid and are 0 when chk_valid_o=0.
- alert_o:
  - Set the cycle after a registered double error.
  - Held until clr_alert_i=1.
  - If set and clear occur in the same cycle, set wins.
- Counters:
  - Increment on each valid single or double error.
  - Saturate at all-ones (no wrap).
  - Cleared only by reset.
- Reset (rst_i=1 at a clock edge), which also aborts any in-flight check: all registered outputs go to 0 (chk_valid_o, chk_data_o, syndrome_o, err_*, alert_o, counters). enc_o stays combinational.
- X on chk inputs is don't-care while chk_valid_i=0.

Decomposition:
- Package secded_inv_pkg holds the mask constants M0..M6, InvMask, a 7-bit syndrome typedef, and the 39-bit codeword typedef.
- One sub-module, secded_inv_39_32_enc_core: a combinational encoder.
  - Instantiated twice: once for the encode path, once to recompute check bits in the check path.

Test Plan:
- enc_data_i=32'h0 -> enc_o[38:32]=7'h2A; enc_data_i=32'hFFFFFFFF -> 7'h2A; enc_data_i=32'h00000013 -> 7'h7D.
- Check data 32'h13 with intg 7'h7D, valid=1 -> next cycle chk_data_o=32'h13, syndrome 0, no error flags.
- Check data 32'h33 (bit 5 flipped) with intg 7'h7D -> chk_data_o=32'h13, err_single_o=1, single_cnt_o=1.
- Check data 32'h13 with intg 7'h7C (check bit flipped) -> err_single_o=1, chk_data_o=32'h13.
- Check data 32'h10 (bits 0,1 flipped) with intg 7'h7D -> err_double_o=1, alert_o=1 and sticky until clr_alert_i; double_cnt_o=1.
- Assert rst_i while chk_valid_i=1 -> next cycle all outputs 0. 256 single errors -> single_cnt_o saturates at 8'hFF.
